// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard FSM state encoding, register-zero constant,
// decoder opcode constants and the hazard control bundle.
package cpu_pkg;

   localparam int unsigned REG_W = 5;

   // Hazard sequencer states
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD_WAIT  = 2'd1,
      MD_DRAIN = 2'd2
   } hz_state_e;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   // Opcodes and ALU ops used by the decoder
   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_J    = 5'b00001;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JAL  = 5'b00011;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SETX = 5'b10101;
   localparam logic [4:0] OP_BEX  = 5'b10110;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   // Pipeline latch control bundle
   typedef struct packed {
      logic stall_pc;
      logic stall_fd;
      logic stall_dx;
      logic bubble_dx;
      logic bubble_xm;
      logic flush_fd;
      logic md_start;
   } hz_ctl_t;

   // True when a live (non-r0) destination matches a source register
   function automatic logic reg_hit(input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] rs);
      return (rd != REG_ZERO) && (rd == rs);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the F/D and D/X instructions.
// Ports: fd_rs1/fd_rs2/fd_uses_rs2/fd_is_store describe the F/D reader,
//        dx_rd/dx_rwe/dx_is_load describe the D/X writer,
//        hazard_c is high when the F/D instruction must wait one cycle.
module load_use_detect
   import cpu_pkg::*;
(
   input  logic [REG_W-1:0] fd_rs1,
   input  logic [REG_W-1:0] fd_rs2,
   input  logic             fd_uses_rs2,
   input  logic             fd_is_store,
   input  logic [REG_W-1:0] dx_rd,
   input  logic             dx_rwe,
   input  logic             dx_is_load,
   output logic             hazard_c
);

   logic live_load;
   logic hit_rs1;
   logic hit_rs2;

   assign live_load = dx_is_load & dx_rwe;
   assign hit_rs1   = reg_hit(dx_rd, fd_rs1);
   // Store data is forwarded M/W->X/M, so a sw rs2 match needs no stall
   assign hit_rs2   = reg_hit(dx_rd, fd_rs2) & fd_uses_rs2 & ~fd_is_store;
   assign hazard_c  = live_load & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, mult/div occupancy and
// control-flow flushes for the 5-stage CPU.
// Ports: clock/reset (sync, active-high); F/D and D/X hazard info in;
//        md_ready/x_redirect in; latch stall/bubble/flush controls out;
//        md_start pulse, md_busy, sticky md_timeout, saturating stall_cycles.
module hazard_stall_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned MD_TIMEOUT = 40,
   parameter int unsigned CNT_W      = 32
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_W-1:0]  fd_rs1,
   input  logic [REG_W-1:0]  fd_rs2,
   input  logic              fd_uses_rs2,
   input  logic              fd_is_store,
   input  logic [REG_W-1:0]  dx_rd,
   input  logic              dx_rwe,
   input  logic              dx_is_load,
   input  logic              dx_is_md,
   input  logic              md_ready,
   input  logic              x_redirect,
   output logic              stall_pc,
   output logic              stall_fd,
   output logic              stall_dx,
   output logic              bubble_dx,
   output logic              bubble_xm,
   output logic              flush_fd,
   output logic              md_start,
   output logic              md_busy,
   output logic              md_timeout,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int unsigned TO_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

   hz_state_e         state_q;
   hz_state_e         state_d;
   hz_ctl_t           ctl;
   logic              busy;
   logic              to_clr;
   logic              to_fire;
   logic              load_use;
   logic [TO_W-1:0]   to_cnt_q;
   logic              md_timeout_q;
   logic [CNT_W-1:0]  stall_cycles_q;

   load_use_detect u_lu (
      .fd_rs1      (fd_rs1),
      .fd_rs2      (fd_rs2),
      .fd_uses_rs2 (fd_uses_rs2),
      .fd_is_store (fd_is_store),
      .dx_rd       (dx_rd),
      .dx_rwe      (dx_rwe),
      .dx_is_load  (dx_is_load),
      .hazard_c    (load_use)
   );

   // State register
   always_ff @(posedge clock) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // Next state and latch controls; reset forces everything quiet this cycle
   always_comb begin
      state_d = state_q;
      ctl     = '0;
      busy    = 1'b0;
      to_clr  = 1'b0;
      to_fire = 1'b0;
      if (!reset) begin
         case (state_q)
            RUN: begin
               if (x_redirect) begin
                  // D/X is wrong-path: squash it, even a pending mul/div
                  ctl.flush_fd  = 1'b1;
                  ctl.bubble_dx = 1'b1;
               end else if (dx_is_md) begin
                  ctl.md_start  = 1'b1;
                  ctl.bubble_xm = 1'b1;
                  ctl.stall_pc  = 1'b1;
                  ctl.stall_fd  = 1'b1;
                  ctl.stall_dx  = 1'b1;
                  to_clr        = 1'b1;
                  state_d       = MD_WAIT;
               end else if (load_use) begin
                  ctl.stall_pc  = 1'b1;
                  ctl.stall_fd  = 1'b1;
                  ctl.bubble_dx = 1'b1;
               end
            end
            MD_WAIT: begin
               // X holds a bubble here, so a redirect cannot be pending
               ctl.stall_pc  = 1'b1;
               ctl.stall_fd  = 1'b1;
               ctl.stall_dx  = 1'b1;
               ctl.bubble_xm = 1'b1;
               busy          = 1'b1;
               if (md_ready) begin
                  state_d = MD_DRAIN;
               end else if (to_cnt_q == TO_LAST) begin
                  to_fire = 1'b1;
                  state_d = MD_DRAIN;
               end
            end
            MD_DRAIN: begin
               // md instruction still visible in D/X must not restart
               state_d = RUN;
               if (x_redirect) begin
                  ctl.flush_fd  = 1'b1;
                  ctl.bubble_dx = 1'b1;
               end else if (load_use) begin
                  ctl.stall_pc  = 1'b1;
                  ctl.stall_fd  = 1'b1;
                  ctl.bubble_dx = 1'b1;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // MD_WAIT occupancy counter
   always_ff @(posedge clock) begin
      if (reset)       to_cnt_q <= '0;
      else if (to_clr) to_cnt_q <= '0;
      else if (busy)   to_cnt_q <= to_cnt_q + TO_W'(1);
   end

   // Sticky timeout flag
   always_ff @(posedge clock) begin
      if (reset)        md_timeout_q <= 1'b0;
      else if (to_fire) md_timeout_q <= 1'b1;
   end

   // Saturating stall-cycle performance counter
   always_ff @(posedge clock) begin
      if (reset)
         stall_cycles_q <= '0;
      else if (ctl.stall_pc && (stall_cycles_q != {CNT_W{1'b1}}))
         stall_cycles_q <= stall_cycles_q + CNT_W'(1);
   end

   assign stall_pc     = ctl.stall_pc;
   assign stall_fd     = ctl.stall_fd;
   assign stall_dx     = ctl.stall_dx;
   assign bubble_dx    = ctl.bubble_dx;
   assign bubble_xm    = ctl.bubble_xm;
   assign flush_fd     = ctl.flush_fd;
   assign md_start     = ctl.md_start;
   assign md_busy      = busy;
   assign md_timeout   = md_timeout_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl (MD_TIMEOUT=8, CNT_W=4).
// Stimulus pushes the hand-computed per-cycle expectation; a negedge monitor
// pops and compares against the DUT outputs.
// Control vector bit order: {stall_pc,stall_fd,stall_dx,bubble_dx,bubble_xm,
//                            flush_fd,md_start,md_busy,md_timeout}
module tb_hazard_stall_ctrl;

   logic       clock;
   logic       reset;
   logic [4:0] fd_rs1;
   logic [4:0] fd_rs2;
   logic       fd_uses_rs2;
   logic       fd_is_store;
   logic [4:0] dx_rd;
   logic       dx_rwe;
   logic       dx_is_load;
   logic       dx_is_md;
   logic       md_ready;
   logic       x_redirect;
   logic       stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd;
   logic       md_start, md_busy, md_timeout;
   logic [3:0] stall_cycles;

   typedef struct {
      string      name;
      logic [8:0] ctl;
      logic [3:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   localparam logic [8:0] C_IDLE  = 9'b000000000;
   localparam logic [8:0] C_LU    = 9'b110100000;
   localparam logic [8:0] C_RDIR  = 9'b000101000;
   localparam logic [8:0] C_START = 9'b111010100;
   localparam logic [8:0] C_WAIT  = 9'b111010010;
   localparam logic [8:0] C_TMO   = 9'b000000001;

   hazard_stall_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .fd_rs1       (fd_rs1),
      .fd_rs2       (fd_rs2),
      .fd_uses_rs2  (fd_uses_rs2),
      .fd_is_store  (fd_is_store),
      .dx_rd        (dx_rd),
      .dx_rwe       (dx_rwe),
      .dx_is_load   (dx_is_load),
      .dx_is_md     (dx_is_md),
      .md_ready     (md_ready),
      .x_redirect   (x_redirect),
      .stall_pc     (stall_pc),
      .stall_fd     (stall_fd),
      .stall_dx     (stall_dx),
      .bubble_dx    (bubble_dx),
      .bubble_xm    (bubble_xm),
      .flush_fd     (flush_fd),
      .md_start     (md_start),
      .md_busy      (md_busy),
      .md_timeout   (md_timeout),
      .stall_cycles (stall_cycles)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Monitor: one expectation per cycle, sampled mid-cycle
   always @(negedge clock) begin
      logic [8:0] act;
      exp_t       e;
      act = {stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm,
             flush_fd, md_start, md_busy, md_timeout};
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_tests++;
         if (act !== e.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
         end
         n_tests++;
         if (stall_cycles !== e.cnt) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d expected %0d",
                     e.name, stall_cycles, e.cnt);
         end
         n_tests++;
         if ((flush_fd & stall_fd) || (bubble_dx & stall_dx)) begin
            n_fail++;
            $display("FAIL %s invariant: flush_fd=%b stall_fd=%b bubble_dx=%b stall_dx=%b expected no overlap",
                     e.name, flush_fd, stall_fd, bubble_dx, stall_dx);
         end
      end
   end

   task automatic idle_in();
      fd_rs1      = 5'd1;
      fd_rs2      = 5'd2;
      fd_uses_rs2 = 1'b0;
      fd_is_store = 1'b0;
      dx_rd       = 5'd0;
      dx_rwe      = 1'b0;
      dx_is_load  = 1'b0;
      dx_is_md    = 1'b0;
      md_ready    = 1'b0;
      x_redirect  = 1'b0;
   endtask

   task automatic lu_in(input logic [4:0] rd, input logic [4:0] rs1);
      idle_in();
      dx_is_load = 1'b1;
      dx_rwe     = 1'b1;
      dx_rd      = rd;
      fd_rs1     = rs1;
   endtask

   task automatic expect_c(input string nm, input logic [8:0] c, input logic [3:0] n);
      exp_t e;
      e.name = nm;
      e.ctl  = c;
      e.cnt  = n;
      sb.push_back(e);
   endtask

   task automatic nxt();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle_in();
      nxt();
      // Reset holds all controls low even with an md instruction in D/X
      dx_is_md = 1'b1;
      expect_c("reset", C_IDLE, 4'd0); nxt();

      // Load-use on rs1
      reset = 1'b0;
      lu_in(5'd5, 5'd5);          expect_c("lu_rs1", C_LU, 4'd0); nxt();
      idle_in();                  expect_c("lu_release", C_IDLE, 4'd1); nxt();
      lu_in(5'd0, 5'd0);          expect_c("lu_r0", C_IDLE, 4'd1); nxt();

      // Store-data exemption
      lu_in(5'd7, 5'd2); fd_rs2 = 5'd7; fd_uses_rs2 = 1'b1; fd_is_store = 1'b1;
      expect_c("sw_data_exempt", C_IDLE, 4'd1); nxt();
      lu_in(5'd7, 5'd7); fd_rs2 = 5'd7; fd_uses_rs2 = 1'b1; fd_is_store = 1'b1;
      expect_c("sw_base_stall", C_LU, 4'd1); nxt();
      idle_in();                  expect_c("sw_release", C_IDLE, 4'd2); nxt();
      lu_in(5'd7, 5'd2); fd_rs2 = 5'd7; fd_uses_rs2 = 1'b1;
      expect_c("lu_rs2", C_LU, 4'd2); nxt();
      idle_in();                  expect_c("lu_rs2_release", C_IDLE, 4'd3); nxt();
      lu_in(5'd7, 5'd2); fd_rs2 = 5'd7;
      expect_c("rs2_unused", C_IDLE, 4'd3); nxt();
      lu_in(5'd5, 5'd5); dx_rwe = 1'b0;
      expect_c("lu_no_rwe", C_IDLE, 4'd3); nxt();
      lu_in(5'd5, 5'd5); x_redirect = 1'b1;
      expect_c("redirect_over_lu", C_RDIR, 4'd3); nxt();

      reset = 1'b1; idle_in();    expect_c("reset2", C_IDLE, 4'd3); nxt();
      reset = 1'b0;               expect_c("after_reset2", C_IDLE, 4'd0); nxt();

      // Mult: md_ready in the start cycle is ignored, ready in 4th wait cycle
      dx_is_md = 1'b1; md_ready = 1'b1;
      expect_c("md_start", C_START, 4'd0); nxt();
      md_ready = 1'b0;            expect_c("md_w1", C_WAIT, 4'd1); nxt();
      x_redirect = 1'b1;          expect_c("md_w2_redirect", C_WAIT, 4'd2); nxt();
      x_redirect = 1'b0;          expect_c("md_w3", C_WAIT, 4'd3); nxt();
      md_ready = 1'b1;            expect_c("md_w4_ready", C_WAIT, 4'd4); nxt();
      md_ready = 1'b0;            expect_c("md_drain", C_IDLE, 4'd5); nxt();
      idle_in();                  expect_c("md_run", C_IDLE, 4'd5); nxt();

      // Redirect beats md in the same cycle
      dx_is_md = 1'b1; x_redirect = 1'b1;
      expect_c("redirect_vs_md", C_RDIR, 4'd5); nxt();
      idle_in();                  expect_c("redirect_stay_run", C_IDLE, 4'd5); nxt();

      reset = 1'b1;               expect_c("reset3", C_IDLE, 4'd5); nxt();

      // Timeout after 8 wait cycles
      reset = 1'b0; dx_is_md = 1'b1;
      expect_c("to_start", C_START, 4'd0); nxt();
      for (int k = 1; k <= 8; k++) begin
         expect_c("to_wait", C_WAIT, 4'(k)); nxt();
      end
      lu_in(5'd5, 5'd5);
      expect_c("to_drain_lu", C_LU | C_TMO, 4'd9); nxt();
      idle_in();                  expect_c("to_sticky", C_TMO, 4'd10); nxt();

      // Back-to-back md instructions restart after drain
      dx_is_md = 1'b1;            expect_c("b2b_start1", C_START | C_TMO, 4'd10); nxt();
      md_ready = 1'b1;            expect_c("b2b_w1", C_WAIT | C_TMO, 4'd11); nxt();
      md_ready = 1'b0;            expect_c("b2b_drain", C_TMO, 4'd12); nxt();
      expect_c("b2b_start2", C_START | C_TMO, 4'd12); nxt();
      expect_c("b2b_w1b", C_WAIT | C_TMO, 4'd13); nxt();
      reset = 1'b1;               expect_c("reset_mid_wait", C_TMO, 4'd14); nxt();
      reset = 1'b0; idle_in();    expect_c("after_reset_mid_wait", C_IDLE, 4'd0); nxt();

      // Saturating counter under a held load-use stall
      lu_in(5'd9, 5'd9);
      for (int k = 0; k < 20; k++) begin
         expect_c("sat_hold", C_LU, (k > 15) ? 4'd15 : 4'(k)); nxt();
      end
      idle_in();                  expect_c("sat_final", C_IDLE, 4'd15); nxt();

      nxt();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard sequencer for the 5-stage CPU. It works alongside the operand bypass network and covers the cases forwarding cannot resolve:
- load-use hazards;
- multi-cycle mult/div occupancy;
- control-flow flushes.

It drives the PC/FD/DX/XM latch enables and bubble inserts, and issues the single-cycle start pulse to the multdiv unit.

Parameters:
MD_TIMEOUT, 40, max cycles in MD_WAIT before forced release
CNT_W, 32, width of stall-cycle performance counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
fd_rs1  in  5  source reg A of instruction in F/D
fd_rs2  in  5  source reg B (rt/rd per decoder) of instruction in F/D
fd_uses_rs2  in  1  F/D instruction reads rs2
fd_is_store  in  1  F/D instruction is sw (rs2 = store data)
dx_rd  in  5  destination of instruction in D/X
dx_rwe  in  1  D/X register write enable
dx_is_load  in  1  D/X mem_to_reg (lw)
dx_is_md  in  1  D/X is mul or div
md_ready  in  1  multdiv result valid
x_redirect  in  1  taken branch / jr / jump resolved in X
stall_pc  out  1  hold PC
stall_fd  out  1  hold F/D latch
stall_dx  out  1  hold D/X latch
bubble_dx  out  1  load nop into D/X
bubble_xm  out  1  load nop into X/M
flush_fd  out  1  load nop into F/D
md_start  out  1  one-cycle start pulse to multdiv
md_busy  out  1  FSM in MD_WAIT
md_timeout  out  1  sticky; set on timeout, cleared by reset
stall_cycles  out  CNT_W  saturating count of cycles with stall_pc=1

Behaviour:
- Clock and reset:
  - Single clock `clock`; reset is synchronous, active-high, port `reset`.
  - On reset: FSM=RUN, timeout counter=0, md_timeout=0, stall_cycles=0, all outputs 0.
  - Reset in any state, including MD_WAIT, aborts immediately; no md_start is issued that cycle.
- FSM states: RUN, MD_WAIT, MD_DRAIN.
- Combinational outputs in RUN, evaluated in priority order (highest first):
  1. x_redirect: flush_fd=1, bubble_dx=1. No stall and no md_start, even if dx_is_md, because the D/X instruction is wrong-path. Stay RUN.
  2. dx_is_md:
     - md_start=1 and bubble_xm=1 this cycle.
     - stall_pc, stall_fd and stall_dx =1.
     - Next state MD_WAIT; timeout counter cleared.
  3. Load-use: applies when dx_is_load & dx_rwe & dx_rd!=0 and either:
     - dx_rd==fd_rs1, or
     - dx_rd==fd_rs2 & fd_uses_rs2 & !fd_is_store. A store-data dependency is not a stall; it is forwarded M/W->X/M.

     Response: stall_pc=1, stall_fd=1, bubble_dx=1 for exactly one cycle; stay RUN.
  4. Otherwise all controls 0.
- MD_WAIT:
  - stall_pc, stall_fd, stall_dx and bubble_xm =1; md_busy=1; counter increments each cycle.
  - md_ready is sampled only in MD_WAIT; a md_ready in the md_start cycle is ignored.
  - md_ready=1 -> MD_DRAIN.
  - Counter == MD_TIMEOUT-1 without md_ready -> set md_timeout, go MD_DRAIN.
  - x_redirect is ignored here; X holds a bubble.
- MD_DRAIN (1 cycle):
  - All stalls released; bubble_xm=0, so the md instruction advances to X/M and latches the result.
  - Next state RUN.
  - No new md_start this cycle, even if dx_is_md is still visible.
  - Load-use and redirect logic are evaluated as in RUN.
- Latency and throughput:
  - Load-use costs exactly 1 bubble.
  - A mult/div costs N+2 stall-free-issue cycles, where N is the number of MD_WAIT cycles.
  - Back-to-back md instructions restart after MD_DRAIN.
- stall_cycles: +1 every cycle stall_pc=1; saturates at all-ones, no wrap.
- Invariant: flush_fd and stall_fd are never both 1; bubble_dx and stall_dx are never both 1.

Decomposition:
- Shared package (cpu_pkg):
  - FSM state encoding constants (RUN=2'd0, MD_WAIT=2'd1, MD_DRAIN=2'd2);
  - register-zero constant 5'd0;
  - opcode constants already used by the decoder.
- One sub-module, load_use_detect: the purely combinational load-use compare. Keeps the FSM file focused.

Test Plan:
- Load-use: lw r5 in D/X, add using r5 as rs1 in F/D -> stall_pc/stall_fd/bubble_dx=1 for one cycle, then 0; stall_cycles=1. Same with dx_rd=0 -> no stall.
- Store-data exemption: lw r7 in D/X, sw with fd_rs2=7, fd_is_store=1, fd_rs1=2 -> no stall. Same with fd_rs1=7 -> 1-cycle stall.
- Mult with md_ready 4 cycles after start:
  - md_start pulses exactly 1 cycle.
  - md_busy=1 for 4 cycles; stalls held for 5 cycles; MD_DRAIN releases.
  - stall_cycles=5.
- Redirect vs md: x_redirect=1 and dx_is_md=1 same cycle -> flush_fd=1, bubble_dx=1, md_start=0, state stays RUN.
- Timeout: MD_TIMEOUT=8, md_ready never asserted -> after 8 MD_WAIT cycles md_timeout=1 (sticky), pipeline released. Reset asserted mid-MD_WAIT -> next cycle all outputs 0, state RUN.
- Saturation: CNT_W=4, hold load-use stall 20 cycles -> stall_cycles stays 4'hF.
